// File: rtl/maxpool_l1.sv
// 2x2 stride-2 max-pool from the layer-0 / kernel-0 bank into the layer-1 bank over
// the shared layer memory bus; one output is read, reduced and written every 6 cycles.
module maxpool_l1 #(
  parameter int          IMG_W   = 64,
  parameter int          DW      = 20,
  parameter int          AW      = 12,
  parameter logic [2:0]  SEL_SRC = 3'b001,
  parameter logic [2:0]  SEL_DST = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int LW = $clog2(IMG_W);
  localparam int CW = $clog2(IMG_W / 2);
  localparam logic [CW-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_R0, S_R1, S_R2, S_R3, S_CAP, S_WR, S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   r_q, c_q;
  logic [DW-1:0]   mx_q;
  logic            busy_q, crd_q, cwr_q;
  logic [2:0]      csel_q;
  logic [AW-1:0]   caddr_rd_q, caddr_wr_q;
  logic [DW-1:0]   cdata_wr_q;

  logic [CW-1:0]   r_d, c_d;
  logic [DW-1:0]   mx_d;
  logic            last_d;

  // Source address of one pixel of window (r,c); dy/dx pick the slot inside the 2x2 window.
  function automatic logic [AW-1:0] src_addr(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                             input logic dy, input logic dx);
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = AW'({r, dy});
    col = AW'({c, dx});
    return (row << LW) | col;
  endfunction

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] d, input logic [DW-1:0] m);
    return ($signed(d) > $signed(m)) ? d : m;
  endfunction

  always_comb begin
    c_d    = c_q + 1'b1;
    r_d    = (c_q == LAST) ? r_q + 1'b1 : r_q;
    last_d = (r_q == LAST) && (c_q == LAST);
    // The R1 capture is the first of a window and loads instead of comparing.
    mx_d   = (state_q == S_R1) ? cdata_rd : smax(cdata_rd, mx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      mx_q       <= '0;
      busy_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= 3'b000;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ready) begin
            state_q    <= S_R0;
            busy_q     <= 1'b1;
            r_q        <= '0;
            c_q        <= '0;
            crd_q      <= 1'b1;
            csel_q     <= SEL_SRC;
            caddr_rd_q <= '0;
          end
        end
        S_R0: begin
          state_q    <= S_R1;
          caddr_rd_q <= src_addr(r_q, c_q, 1'b0, 1'b1);
        end
        S_R1: begin
          state_q    <= S_R2;
          mx_q       <= mx_d;
          caddr_rd_q <= src_addr(r_q, c_q, 1'b1, 1'b0);
        end
        S_R2: begin
          state_q    <= S_R3;
          mx_q       <= mx_d;
          caddr_rd_q <= src_addr(r_q, c_q, 1'b1, 1'b1);
        end
        S_R3: begin
          state_q <= S_CAP;
          mx_q    <= mx_d;
          crd_q   <= 1'b0;
          csel_q  <= 3'b000;
        end
        S_CAP: begin
          // Final capture folds straight into the write data so WR needs no extra cycle.
          state_q    <= S_WR;
          mx_q       <= mx_d;
          cwr_q      <= 1'b1;
          csel_q     <= SEL_DST;
          caddr_wr_q <= AW'({r_q, c_q});
          cdata_wr_q <= mx_d;
        end
        S_WR: begin
          cwr_q <= 1'b0;
          if (last_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            csel_q  <= 3'b000;
          end else begin
            state_q    <= S_R0;
            r_q        <= r_d;
            c_q        <= c_d;
            crd_q      <= 1'b1;
            csel_q     <= SEL_SRC;
            caddr_rd_q <= src_addr(r_d, c_d, 1'b0, 1'b0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          crd_q   <= 1'b0;
          cwr_q   <= 1'b0;
          csel_q  <= 3'b000;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign crd      = crd_q;
  assign cwr      = cwr_q;
  assign csel     = csel_q;
  assign caddr_rd = caddr_rd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_maxpool_l1.sv
// Directed bench for maxpool_l1: layer memories, bus monitor and a linear run sequence
// covering ramp, signed/tie windows, handshake, protocol and mid-run reset.
module tb_maxpool_l1;

  logic        clk;
  logic        reset;
  logic        ready;
  logic        busy;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  logic [19:0] l0 [0:4095];
  logic [19:0] l1 [0:1023];

  int tests = 0;
  int fails = 0;
  int rd_n = 0;
  int wr_n = 0;
  int busy_cyc = 0;
  int seq_err = 0;
  int proto_err = 0;
  logic busy_prev = 1'b0;

  maxpool_l1 dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer-0 memory: registered read, data valid the cycle after crd.
  always @(posedge clk) begin
    if (crd) cdata_rd <= l0[caddr_rd];
  end

  function automatic logic [11:0] exp_rd(input int n);
    int o, s, r, c;
    o = n >> 2;
    s = n & 3;
    r = o >> 5;
    c = o & 31;
    return 12'((2 * r + (s >> 1)) * 64 + 2 * c + (s & 1));
  endfunction

  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      rd_n = 0;
      wr_n = 0;
      busy_cyc = 0;
    end
    busy_prev = busy;
    if (busy === 1'b1) busy_cyc++;
    if (crd === 1'b1 && cwr === 1'b1) proto_err++;
    if (crd === 1'b1 && csel !== 3'b001) proto_err++;
    if (cwr === 1'b1 && csel !== 3'b011) proto_err++;
    if (crd !== 1'b1 && cwr !== 1'b1 && csel !== 3'b000) proto_err++;
    if (crd === 1'b1) begin
      if (caddr_rd !== exp_rd(rd_n)) seq_err++;
      rd_n++;
    end
    if (cwr === 1'b1) begin
      if (caddr_wr >= 12'd1024) proto_err++;
      if (caddr_wr !== 12'(wr_n)) seq_err++;
      l1[caddr_wr[9:0]] = cdata_wr;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic val, input int lim, input string tag);
    int n = 0;
    while (busy !== val && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, busy}, {31'd0, val});
  endtask

  task automatic pulse_ready();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); #1 ready = 1'b0;
  endtask

  task automatic set_win(input int base, input logic [19:0] v0, input logic [19:0] v1,
                         input logic [19:0] v2, input logic [19:0] v3);
    l0[base]      = v0;
    l0[base + 1]  = v1;
    l0[base + 64] = v2;
    l0[base + 65] = v3;
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_reads"}, rd_n, 4096);
    chk({tag, "_writes"}, wr_n, 1024);
    chk({tag, "_busy_cycles"}, busy_cyc, 6144);
  endtask

  task automatic chk_windows(input string tag);
    chk({tag, "_signed_neg"}, {12'd0, l1[0]}, 32'h000F0000);
    chk({tag, "_signed_zero"}, {12'd0, l1[1]}, 32'h00000000);
    chk({tag, "_slot0"}, {12'd0, l1[2]}, 32'h00012000);
    chk({tag, "_slot1"}, {12'd0, l1[3]}, 32'h00012001);
    chk({tag, "_slot2"}, {12'd0, l1[4]}, 32'h00012002);
    chk({tag, "_slot3"}, {12'd0, l1[5]}, 32'h00012003);
    chk({tag, "_all_equal"}, {12'd0, l1[6]}, 32'h00012345);
    chk({tag, "_extremes"}, {12'd0, l1[7]}, 32'h0007FFFF);
    chk({tag, "_all_min"}, {12'd0, l1[8]}, 32'h00080000);
    chk({tag, "_last"}, {12'd0, l1[1023]}, 32'h00000777);
  endtask

  initial begin
    int err;
    int n;
    reset = 1'b1;
    ready = 1'b0;
    for (int a = 0; a < 4096; a++) l0[a] = 20'(a << 16);

    // Reset state
    #2 reset = 1'b0;
    #2;
    chk("rst_ctrl", {27'd0, busy, crd, cwr, csel}, 32'd0);
    chk("rst_addr_rd", {20'd0, caddr_rd}, 32'd0);
    chk("rst_addr_wr", {20'd0, caddr_wr}, 32'd0);
    chk("rst_data_wr", {12'd0, cdata_wr}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("idle_busy", {31'd0, busy}, 32'd0);

    // Ramp run
    pulse_ready();
    wait_busy(1'b1, 4, "ramp_start");
    wait_busy(1'b0, 7000, "ramp_done");
    chk_run("ramp");
    err = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if (l1[r * 32 + c] !== 20'(((2 * r + 1) * 64 + 2 * c + 1) << 16)) err++;
    chk("ramp_all", err, 0);
    chk("ramp_l1_0", {12'd0, l1[0]}, 32'h00010000);
    chk("ramp_l1_3", {12'd0, l1[3]}, 32'h00070000);
    chk("ramp_l1_7", {12'd0, l1[7]}, 32'h000F0000);
    chk("ramp_l1_1023", {12'd0, l1[1023]}, 32'h000F0000);
    chk("ramp_seq", seq_err, 0);

    // Signed / tie / position windows on a most-negative background
    for (int a = 0; a < 4096; a++) l0[a] = 20'h80000;
    set_win(0,  20'hB0000, 20'hF0000, 20'hD0000, 20'h80000);
    set_win(2,  20'h00000, 20'hF0000, 20'hF0000, 20'hF0000);
    set_win(4,  20'h12000, 20'h00100, 20'hFFFFF, 20'h00FFF);
    set_win(6,  20'h00100, 20'h12001, 20'hFFFFF, 20'h00FFF);
    set_win(8,  20'h00100, 20'hFFFFF, 20'h12002, 20'h00FFF);
    set_win(10, 20'h00100, 20'hFFFFF, 20'h00FFF, 20'h12003);
    set_win(12, 20'h12345, 20'h12345, 20'h12345, 20'h12345);
    set_win(14, 20'h80000, 20'h7FFFF, 20'h80000, 20'h80000);
    set_win(62 * 64 + 62, 20'hFFFFF, 20'h00001, 20'h00777, 20'h80000);

    pulse_ready();
    wait_busy(1'b1, 4, "pat_start");
    // Ready toggling while busy must not disturb the run
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ready = ~ready;
    end
    ready = 1'b0;
    n = 0;
    while (wr_n < 1020 && n < 7000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pat_reach_1020", {31'd0, wr_n >= 1020}, 32'd1);
    ready = 1'b1;
    wait_busy(1'b0, 1000, "pat_done");
    chk("done_strobes", {28'd0, crd, cwr, csel[1:0]}, 32'd0);
    chk("done_csel", {29'd0, csel}, 32'd0);
    chk_run("pat");
    chk_windows("pat");
    wait_busy(1'b1, 4, "held_ready_restart");
    ready = 1'b0;
    wait_busy(1'b0, 7000, "rerun_done");
    chk_run("rerun");
    chk_windows("rerun");

    // Reset mid-R2 of output 500
    pulse_ready();
    wait_busy(1'b1, 4, "abort_start");
    n = 0;
    while (wr_n < 500 && n < 4000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_reach_500", wr_n, 500);
    repeat (3) @(posedge clk);
    #2;
    chk("abort_r2_crd", {31'd0, crd}, 32'd1);
    chk("abort_r2_addr", {20'd0, caddr_rd}, 32'd2024);
    reset = 1'b0;
    #1;
    chk("abort_ctrl", {27'd0, busy, crd, cwr, csel}, 32'd0);
    chk("abort_addr", {8'd0, caddr_rd, caddr_wr}, 32'd0);
    chk("abort_data", {12'd0, cdata_wr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // Clean run after reset
    pulse_ready();
    chk("clean_first_rd", {19'd0, crd, caddr_rd}, {19'd0, 1'b1, 12'd0});
    wait_busy(1'b0, 7000, "clean_done");
    chk_run("clean");
    chk_windows("clean");
    chk("seq_all", seq_err, 0);
    chk("protocol", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
